// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch unit.
// Issues word-aligned fetch requests to instruction memory and tags each
// outstanding request with its PC in a small address FIFO. Returned words
// land in a 2-entry in-order {pc, data} buffer that feeds decode.
// The request credit (outstanding + buffered < 2) guarantees that every
// response has a free buffer slot. A redirect flushes the buffer. Responses
// that are still in flight at the redirect are counted off in DRAIN and
// discarded.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  // Instruction memory request channel
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  // Instruction memory response channel
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  // Redirect from downstream
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // Decode channel
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]  state;
  logic [31:0] fetch_pc;
  logic [1:0]  outstanding;  // requests accepted, response not yet seen
  logic [1:0]  drop_cnt;     // in-flight responses to discard after a redirect

  // Address FIFO: the PC of each outstanding request, in issue order.
  logic [31:0] tag_pc [2];
  logic        tag_wr;
  logic        tag_rd;

  // Instruction buffer: {pc, data} pairs waiting for decode.
  logic [31:0] buf_pc   [2];
  logic [31:0] buf_data [2];
  logic        buf_head;
  logic        buf_tail;
  logic [1:0]  buf_count;

  logic        req_fire;
  logic        rsp_fire;
  logic        rsp_push;
  logic        inst_pop;
  logic [2:0]  credit_used;
  logic [1:0]  out_after_rsp;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire      = imem_rsp_valid && (outstanding != 2'd0);
  assign out_after_rsp = outstanding - {1'b0, rsp_fire};
  assign credit_used   = {1'b0, outstanding} + {1'b0, buf_count};

  // Requests are gated by reset so the output is quiet while reset is held.
  // They are also gated by redirect so no request is accepted in a redirect cycle.
  assign imem_req_valid = !reset && (state == ST_RUN) && !redirect_valid &&
                          (credit_used < 3'd2);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A redirect overrides both the response push and the decode pop.
  assign rsp_push = rsp_fire && (state == ST_RUN) && !redirect_valid;
  assign inst_pop = inst_valid && inst_ready && !redirect_valid;

  // The buffer storage is not reset, so gate the data outputs to zero when the buffer is empty.
  assign inst_valid = (buf_count != 2'd0);
  assign inst_data  = inst_valid ? buf_data[buf_head] : 32'h0;
  assign inst_pc    = inst_valid ? buf_pc[buf_head]   : 32'h0;

  // Control state: FSM, fetch PC, request/response bookkeeping, buffer pointers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
      tag_wr      <= 1'b0;
      tag_rd      <= 1'b0;
      buf_head    <= 1'b0;
      buf_tail    <= 1'b0;
      buf_count   <= 2'd0;
    end else begin
      // req_fire is already low during a redirect, so this holds in every state.
      outstanding <= out_after_rsp + {1'b0, req_fire};

      if (redirect_valid) begin
        fetch_pc  <= redirect_pc & ~32'h3;
        drop_cnt  <= out_after_rsp;
        state     <= (out_after_rsp != 2'd0) ? ST_DRAIN : ST_RUN;
        // Stale tags are abandoned; DRAIN never consumes them.
        tag_rd    <= tag_wr;
        buf_head  <= 1'b0;
        buf_tail  <= 1'b0;
        buf_count <= 2'd0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
          tag_wr   <= ~tag_wr;
        end

        if (state == ST_RUN) begin
          if (rsp_fire) begin
            tag_rd <= ~tag_rd;
          end
        end else if (rsp_fire) begin
          drop_cnt <= drop_cnt - 2'd1;
          if (drop_cnt == 2'd1) begin
            state <= ST_RUN;
          end
        end

        if (rsp_push) begin
          buf_tail <= ~buf_tail;
        end
        if (inst_pop) begin
          buf_head <= ~buf_head;
        end
        buf_count <= buf_count + {1'b0, rsp_push} - {1'b0, inst_pop};
      end
    end
  end

  // Storage arrays: the request tag is written on accept, and the buffer entry is written on push.
  // NOTE: the arrays carry no reset; pointers and counts decide validity, so
  // clearing the contents would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_pc[tag_wr] <= fetch_pc;
    end
    if (rsp_push) begin
      buf_pc[buf_tail]   <= tag_pc[tag_rd];
      buf_data[buf_tail] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed testbench for rv32i_fetch_unit.
// The main instance (RESET_PC = 0) talks to a behavioural memory with a
// selectable response latency. A second instance starts near the top of the
// address space and runs freely, to check that the fetch address wraps.
module tb_rv32i_fetch_unit;

  logic        clk;
  logic        reset;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_inst_valid;
  logic [31:0] w_inst_data;
  logic [31:0] w_inst_pc;

  int n_checks = 0;
  int n_errors = 0;
  int mem_lat  = 1;

  rv32i_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  rv32i_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (w_req_valid),
    .imem_req_addr  (w_req_addr),
    .imem_req_ready (1'b1),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .inst_valid     (w_inst_valid),
    .inst_data      (w_inst_data),
    .inst_pc        (w_inst_pc),
    .inst_ready     (1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory model for the main instance. A request accepted in cycle k is
  // answered during cycle k + mem_lat. The model returns at most one
  // response per cycle, in order.
  logic [31:0] q_addr [$];
  int          q_due  [$];
  int          cyc = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q_addr.delete();
      q_due.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end else begin
      cyc = cyc + 1;
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + mem_lat - 1);
      end
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
        imem_rsp_data  <= 32'h0;
      end
    end
  end

  // Memory for the wrap instance: always ready, 1-cycle latency. It logs the first three accepted addresses.
  logic [31:0] w_log [$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      w_log.delete();
      w_rsp_valid <= 1'b0;
      w_rsp_data  <= 32'h0;
    end else begin
      w_rsp_valid <= w_req_valid;
      w_rsp_data  <= w_req_addr;
      if (w_req_valid && w_log.size() < 3) begin
        w_log.push_back(w_req_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    #1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  // Consume n instructions, starting at first_pc, within budget cycles.
  task automatic expect_stream(input string tag, input logic [31:0] first_pc,
                               input int n, input int budget);
    logic [31:0] exp_pc;
    int          got;
    exp_pc = first_pc;
    got    = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      step();
      if (inst_valid && inst_ready) begin
        check({tag, "_pc"}, inst_pc, exp_pc);
        check({tag, "_data"}, inst_data, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        got++;
      end
    end
    check({tag, "_count"}, got, n);
  endtask

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    mem_lat        = 1;

    // Reset values while reset is held
    step();
    step();
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_wrap_addr", w_req_addr, 32'hFFFF_FFF8);

    // First cycle after release
    step();
    reset = 1'b0;
    #1;
    check("rel_req_valid", imem_req_valid, 1'b1);
    check("rel_req_addr", imem_req_addr, 32'h0);
    check("rel_inst_valid", inst_valid, 1'b0);

    // Straight-line fetch
    expect_stream("line", 32'h0, 4, 40);

    // Wrap instance request sequence
    check("wrap_log_size", w_log.size(), 3);
    if (w_log.size() == 3) begin
      check("wrap_req0", w_log[0], 32'hFFFF_FFF8);
      check("wrap_req1", w_log[1], 32'hFFFF_FFFC);
      check("wrap_req2", w_log[2], 32'h0000_0000);
    end

    // Backpressure: decode stalls for 10 cycles
    inst_ready = 1'b0;
    mem_lat    = 1;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    check("bp_inst_valid", inst_valid, 1'b1);
    check("bp_inst_pc", inst_pc, 32'h0);
    check("bp_inst_data", inst_data, mem_word(32'h0));
    check("bp_req_valid", imem_req_valid, 1'b0);
    step();
    inst_ready = 1'b1;
    #1;
    check("bp_rel_pc0", inst_pc, 32'h0);
    check("bp_rel_req_valid0", imem_req_valid, 1'b0);
    step();
    check("bp_rel_valid1", inst_valid, 1'b1);
    check("bp_rel_pc1", inst_pc, 32'h4);
    check("bp_rel_req_valid1", imem_req_valid, 1'b1);
    check("bp_rel_req_addr1", imem_req_addr, 32'h8);
    expect_stream("bp_cont", 32'h8, 2, 20);

    // Redirect with two requests outstanding (latency 3)
    mem_lat = 3;
    do_reset();
    check("rd_c0_addr", imem_req_addr, 32'h0);
    step();
    check("rd_c1_req_valid", imem_req_valid, 1'b1);
    check("rd_c1_addr", imem_req_addr, 32'h4);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    check("rd_c2_req_valid", imem_req_valid, 1'b0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("rd_drain1_req_valid", imem_req_valid, 1'b0);
    check("rd_drain1_inst_valid", inst_valid, 1'b0);
    step();
    check("rd_drain2_req_valid", imem_req_valid, 1'b0);
    check("rd_drain2_inst_valid", inst_valid, 1'b0);
    step();
    check("rd_resume_req_valid", imem_req_valid, 1'b1);
    check("rd_resume_addr", imem_req_addr, 32'h100);
    check("rd_resume_inst_valid", inst_valid, 1'b0);
    expect_stream("rd_stream", 32'h100, 2, 30);

    // Redirect in the same cycle as a response and a decode pop
    mem_lat = 1;
    do_reset();
    step();
    check("rs_c1_inst_valid", inst_valid, 1'b0);
    step();
    check("rs_c2_inst_valid", inst_valid, 1'b1);
    check("rs_c2_inst_pc", inst_pc, 32'h0);
    check("rs_c2_rsp_valid", imem_rsp_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0202;
    #1;
    check("rs_c2_req_valid", imem_req_valid, 1'b0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("rs_c3_inst_valid", inst_valid, 1'b0);
    check("rs_c3_req_valid", imem_req_valid, 1'b1);
    check("rs_c3_addr", imem_req_addr, 32'h200);
    expect_stream("rs_stream", 32'h200, 3, 30);

    // Asynchronous reset while draining
    mem_lat = 3;
    do_reset();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    check("ar_drain_req_valid", imem_req_valid, 1'b0);
    check("ar_drain_addr", imem_req_addr, 32'h300);
    reset = 1'b1;
    #1;
    check("ar_req_valid", imem_req_valid, 1'b0);
    check("ar_addr", imem_req_addr, 32'h0);
    check("ar_inst_valid", inst_valid, 1'b0);
    check("ar_inst_pc", inst_pc, 32'h0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("ar_rel_req_valid", imem_req_valid, 1'b1);
    check("ar_rel_addr", imem_req_addr, 32'h0);
    expect_stream("ar_stream", 32'h0, 2, 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
